// File: rtl/qam_pkg.sv
// Shared types for the 16-QAM symbol sequencer: level encoding, FSM states
// and the Gray-to-level map used on each 2-bit symbol field.
package qam_pkg;

  typedef logic signed [2:0] qam_level_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } qam_state_t;

  localparam qam_level_t LVL_M3   = 3'sb101;
  localparam qam_level_t LVL_M1   = 3'sb111;
  localparam qam_level_t LVL_P1   = 3'sb001;
  localparam qam_level_t LVL_P3   = 3'sb011;
  localparam qam_level_t LVL_ZERO = 3'sb000;

  // Gray order keeps adjacent constellation points one bit apart.
  function automatic qam_level_t gray2_to_level(input logic [1:0] g);
    qam_level_t lvl;
    case (g)
      2'b00:   lvl = LVL_M3;
      2'b01:   lvl = LVL_M1;
      2'b11:   lvl = LVL_P1;
      default: lvl = LVL_P3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam_step_timer.sv
// Carrier step cadence: divides the clock by STEP_DIV into step pulses and
// counts STEPS_PER_SYMBOL steps; counters sit at zero whenever run_i is low.
module qam_step_timer #(
  parameter int unsigned STEP_DIV         = 10,
  parameter int unsigned STEPS_PER_SYMBOL = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic step_o,
  output logic boundary_o
);

  localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned SW = (STEPS_PER_SYMBOL > 1) ? $clog2(STEPS_PER_SYMBOL) : 1;

  logic [DW-1:0] div_cnt_q;
  logic [SW-1:0] step_cnt_q;
  logic          div_at_max;
  logic          step_at_max;

  assign div_at_max  = (div_cnt_q == DW'(STEP_DIV - 1));
  assign step_at_max = (step_cnt_q == SW'(STEPS_PER_SYMBOL - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q  <= '0;
      step_cnt_q <= '0;
    end else if (!run_i) begin
      div_cnt_q  <= '0;
      step_cnt_q <= '0;
    end else if (div_at_max) begin
      div_cnt_q  <= '0;
      step_cnt_q <= step_at_max ? '0 : step_cnt_q + SW'(1);
    end else begin
      div_cnt_q  <= div_cnt_q + DW'(1);
    end
  end

  assign step_o     = run_i & div_at_max;
  assign boundary_o = step_o & step_at_max;

endmodule

// File: rtl/qam_symbol_sequencer.sv
// 16-QAM transmit sequencer: one-deep symbol buffer feeding held I/Q levels,
// carrier step strobes and carrier phase-hold control.
module qam_symbol_sequencer
  import qam_pkg::*;
#(
  parameter int unsigned STEP_DIV         = 10,
  parameter int unsigned STEPS_PER_SYMBOL = 64,
  parameter int unsigned PRIME_CYCLES     = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              enable_in,
  input  logic              sym_valid_in,
  input  logic [3:0]        sym_data_in,
  output logic              sym_ready_out,
  output logic              step_out,
  output logic              carrier_rst_out,
  output logic signed [2:0] i_level_out,
  output logic signed [2:0] q_level_out,
  output logic              sym_start_out,
  output logic              underrun_out,
  output logic              busy_out
);

  localparam int unsigned PW = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;

  qam_state_t    state_q;
  logic          buf_full_q;
  logic [3:0]    buf_dat_q;
  logic [PW-1:0] prime_cnt_q;
  logic          carrier_rst_q;
  qam_level_t    i_lvl_q;
  qam_level_t    q_lvl_q;
  logic          sym_start_q;
  logic          underrun_q;

  logic          run;
  logic          step;
  logic          boundary;
  logic          accept;
  logic [3:0]    load_dat;

  // Ready is masked during reset so the source never sees a phantom accept.
  assign sym_ready_out = rst_in & enable_in & ~buf_full_q;
  assign accept        = sym_valid_in & sym_ready_out;
  assign load_dat      = buf_full_q ? buf_dat_q : sym_data_in;
  assign run           = (state_q == RUN);

  qam_step_timer #(
    .STEP_DIV         (STEP_DIV),
    .STEPS_PER_SYMBOL (STEPS_PER_SYMBOL)
  ) u_timer (
    .clk_i      (clk_in),
    .rst_ni     (rst_in),
    .run_i      (run),
    .step_o     (step),
    .boundary_o (boundary)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= IDLE;
      buf_full_q    <= 1'b0;
      buf_dat_q     <= '0;
      prime_cnt_q   <= '0;
      carrier_rst_q <= 1'b1;
      i_lvl_q       <= LVL_ZERO;
      q_lvl_q       <= LVL_ZERO;
      sym_start_q   <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      sym_start_q <= 1'b0;
      underrun_q  <= 1'b0;
      if (accept) begin
        buf_full_q <= 1'b1;
        buf_dat_q  <= sym_data_in;
      end
      case (state_q)
        IDLE: begin
          if (buf_full_q && enable_in) begin
            state_q       <= PRIME;
            prime_cnt_q   <= '0;
            buf_full_q    <= 1'b0;
            carrier_rst_q <= 1'b0;
            i_lvl_q       <= gray2_to_level(buf_dat_q[3:2]);
            q_lvl_q       <= gray2_to_level(buf_dat_q[1:0]);
            sym_start_q   <= 1'b1;
          end
        end
        PRIME: begin
          if (prime_cnt_q == PW'(PRIME_CYCLES - 1)) begin
            state_q     <= RUN;
            prime_cnt_q <= '0;
          end else begin
            prime_cnt_q <= prime_cnt_q + PW'(1);
          end
        end
        RUN: begin
          // A symbol accepted on the boundary cycle itself bypasses the buffer.
          if (boundary) begin
            if ((enable_in && buf_full_q) || accept) begin
              buf_full_q  <= 1'b0;
              i_lvl_q     <= gray2_to_level(load_dat[3:2]);
              q_lvl_q     <= gray2_to_level(load_dat[1:0]);
              sym_start_q <= 1'b1;
            end else begin
              state_q       <= IDLE;
              carrier_rst_q <= 1'b1;
              i_lvl_q       <= LVL_ZERO;
              q_lvl_q       <= LVL_ZERO;
              underrun_q    <= enable_in;
            end
          end
        end
        default: begin
          state_q       <= IDLE;
          carrier_rst_q <= 1'b1;
          i_lvl_q       <= LVL_ZERO;
          q_lvl_q       <= LVL_ZERO;
        end
      endcase
    end
  end

  assign step_out        = step;
  assign carrier_rst_out = carrier_rst_q;
  assign i_level_out     = i_lvl_q;
  assign q_level_out     = q_lvl_q;
  assign sym_start_out   = sym_start_q;
  assign underrun_out    = underrun_q;
  assign busy_out        = (state_q != IDLE);

endmodule
